// File: rtl/wb_pkg.sv
// Shared types and width helpers for the round-robin watchdog arbiter.
package wb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    function automatic int gnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A disabled watchdog (timeout 0) still gets a 1-bit counter to keep widths legal.
    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_watchdog_arbiter_rr_pick.sv
// Rotating-priority picker: the first set request strictly after last_i wins,
// wrapping to the lowest set request when nothing above last_i is pending.
module rr_pick
    import wb_pkg::*;
#(
    parameter  int N = 2,
    localparam int W = gnt_width(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] winner_o,
    output logic         valid_o
);

    logic [W-1:0] hi_idx;
    logic [W-1:0] lo_idx;
    logic         hi_found;
    logic         lo_found;

    // Scan downwards so the last hit in each class is its lowest index.
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                lo_idx   = W'(k);
                lo_found = 1'b1;
                if (k > int'(last_i)) begin
                    hi_idx   = W'(k);
                    hi_found = 1'b1;
                end
            end
        end
        valid_o  = lo_found;
        winner_o = hi_found ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/wb_rr_watchdog_arbiter.sv
// Round-robin Wishbone arbiter that holds a grant for the whole cycle and aborts
// a grant whose strobe stays unterminated for TIMEOUT clocks.
module wb_rr_watchdog_arbiter
    import wb_pkg::*;
#(
    parameter  int MASTER_COUNT = 2,
    parameter  int TIMEOUT      = 255,
    localparam int GNT_WIDTH    = gnt_width(MASTER_COUNT)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [MASTER_COUNT-1:0] cyc_i,
    input  logic                    stb_i,
    input  logic                    term_i,
    output logic [GNT_WIDTH-1:0]    gnt_o,
    output logic                    cyc_o,
    output logic                    timeout_o,
    output logic [MASTER_COUNT-1:0] mask_o
);

    localparam int                   CNT_WIDTH = cnt_width(TIMEOUT);
    localparam bit                   WDOG_EN   = (TIMEOUT > 0);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t              state_q;
    logic [GNT_WIDTH-1:0]    gnt_q;
    logic [GNT_WIDTH-1:0]    last_q;
    logic [CNT_WIDTH-1:0]    count_q;
    logic                    cyc_q;
    logic                    timeout_q;
    logic [MASTER_COUNT-1:0] mask_q;
    logic [MASTER_COUNT-1:0] mask_d;
    logic [MASTER_COUNT-1:0] eligible;
    logic [GNT_WIDTH-1:0]    winner;
    logic                    pick_valid;
    logic                    owner_active;
    logic                    stalled;
    logic                    expire;

    assign eligible     = cyc_i & ~mask_q;
    assign owner_active = cyc_i[gnt_q];
    assign stalled      = stb_i & ~term_i;
    // A release or a termination in the same cycle wins over the abort.
    assign expire = WDOG_EN && (state_q == ARB_GRANT) && owner_active && stalled
                    && (count_q == CNT_LAST);
    assign mask_d = (mask_q & cyc_i)
                    | (expire ? (MASTER_COUNT'(1) << gnt_q) : '0);

    rr_pick #(.N(MASTER_COUNT)) u_pick (
        .req_i    (eligible),
        .last_i   (last_q),
        .winner_o (winner),
        .valid_o  (pick_valid)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ARB_IDLE;
            gnt_q     <= '0;
            last_q    <= GNT_WIDTH'(MASTER_COUNT - 1);
            count_q   <= '0;
            cyc_q     <= 1'b0;
            timeout_q <= 1'b0;
            mask_q    <= '0;
        end else begin
            timeout_q <= 1'b0;
            mask_q    <= mask_d;
            case (state_q)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        state_q <= ARB_GRANT;
                        gnt_q   <= winner;
                        last_q  <= winner;
                        cyc_q   <= 1'b1;
                        count_q <= '0;
                    end
                end
                ARB_GRANT: begin
                    if (!owner_active) begin
                        state_q <= ARB_IDLE;
                        cyc_q   <= 1'b0;
                        count_q <= '0;
                    end else if (expire) begin
                        state_q   <= ARB_IDLE;
                        cyc_q     <= 1'b0;
                        timeout_q <= 1'b1;
                        count_q   <= '0;
                    end else if (WDOG_EN && stalled) begin
                        count_q <= count_q + 1'b1;
                    end else begin
                        count_q <= '0;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign gnt_o     = gnt_q;
    assign cyc_o     = cyc_q;
    assign timeout_o = timeout_q;
    assign mask_o    = mask_q;

endmodule
